// File: rtl/code_verifier_pkg.sv
// Shared types for the switch-entry combination lock.
// Status encoding and the one-hot switch decoder.
package code_verifier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTRY  = 3'd1,
    ST_DONE   = 3'd2,
    ST_ERROR  = 3'd3,
    ST_LOCKED = 3'd4
  } status_e;

  localparam int SW_MAX  = 64;
  localparam int IDX_MAX = 6;

  typedef struct packed {
    logic               valid;
    logic [IDX_MAX-1:0] index;
  } onehot_t;

  // valid only when exactly one bit is set
  function automatic onehot_t onehot_index(
    input logic [SW_MAX-1:0] s
  );
    onehot_t r;
    int      n;
    r = '0;
    n = 0;
    for (int i = 0; i < SW_MAX; i++) begin
      if (s[i]) begin
        n++;
        r.index = IDX_MAX'(i);
      end
    end
    r.valid = (n == 1);
    return r;
  endfunction

endpackage

// File: rtl/code_verifier_press.sv
// Rising-press detector for a debounced switch bus.
// Emits a press only on an all-zero to nonzero transition.
import code_verifier_pkg::*;

module press_detect #(
  parameter int SW_W  = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw,
  output logic             press,
  output logic             onehot_valid,
  output logic [IDX_W-1:0] index
);

  logic [SW_W-1:0] sw_last;
  onehot_t         oh;

  always_ff @(posedge clk) begin
    if (!rst) sw_last <= '0;
    else      sw_last <= sw;
  end

  assign oh    = onehot_index(SW_MAX'(sw));
  assign press = (sw != '0) && (sw_last == '0);

  assign onehot_valid =
    oh.valid && (oh.index < IDX_MAX'(SW_W));
  assign index = oh.index[IDX_W-1:0];

endmodule

// File: rtl/code_verifier.sv
// Parametrised combination-lock checker with retry lockout.
// Optional entry timeout enabled by VERIF_TIMEOUT_EN.
import code_verifier_pkg::*;

module code_verifier #(
  parameter int SW_W        = 10,
  parameter int CODE_LEN    = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int IDX_W = (SW_W > 1) ? $clog2(SW_W) : 1,
  parameter int CNT_W = $clog2(CODE_LEN + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SW_W-1:0]           sw,
  input  logic [CODE_LEN*IDX_W-1:0] code,
  input  logic                      clear,
  output logic [2:0]                status,
  output logic [CNT_W-1:0]          digit_cnt,
  output logic [3:0]                tries_left,
  output logic                      unlock_pulse
);

  status_e                   st;
  logic [CODE_LEN*IDX_W-1:0] code_reg;
  logic                      press;
  logic                      oh_valid;
  logic [IDX_W-1:0]          index;
  logic [IDX_W-1:0]          expect_idx;
  logic                      match;
  logic                      last;
  status_e                   fail_st;

  press_detect #(
    .SW_W (SW_W),
    .IDX_W(IDX_W)
  ) u_press (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .press       (press),
    .onehot_valid(oh_valid),
    .index       (index)
  );

  // IDLE compares against the live code, which is latched on that edge
  always_comb begin
    expect_idx = code_reg[IDX_W-1:0];
    for (int k = 0; k < CODE_LEN; k++) begin
      if (digit_cnt == CNT_W'(k))
        expect_idx = code_reg[k*IDX_W +: IDX_W];
    end
    if (st == ST_IDLE) expect_idx = code[IDX_W-1:0];
  end

  assign match   = oh_valid && (index == expect_idx);
  assign last    = (digit_cnt == CNT_W'(CODE_LEN - 1));
  assign fail_st = (tries_left == 4'd1) ? ST_LOCKED : ST_ERROR;
  assign status  = st;

`ifdef VERIF_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] timer;
  logic             timeout;

  always_ff @(posedge clk) begin
    if (!rst)                        timer <= '0;
    else if (st != ST_ENTRY || press) timer <= '0;
    else                             timer <= timer + 1'b1;
  end

  assign timeout = (st == ST_ENTRY) && !press &&
                   (timer == TMR_W'(TIMEOUT_CYC - 1));
`else
  logic timeout;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      st           <= ST_IDLE;
      digit_cnt    <= '0;
      tries_left   <= 4'(MAX_TRIES);
      unlock_pulse <= 1'b0;
      code_reg     <= '0;
    end else begin
      unlock_pulse <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (press) begin
            code_reg <= code;
            if (!match) begin
              st         <= fail_st;
              tries_left <= tries_left - 4'd1;
              digit_cnt  <= '0;
            end else if (CODE_LEN == 1) begin
              st           <= ST_DONE;
              digit_cnt    <= CNT_W'(CODE_LEN);
              tries_left   <= 4'(MAX_TRIES);
              unlock_pulse <= 1'b1;
            end else begin
              st        <= ST_ENTRY;
              digit_cnt <= CNT_W'(1);
            end
          end
        end
        ST_ENTRY: begin
          if ((press && !match) || timeout) begin
            st         <= fail_st;
            tries_left <= tries_left - 4'd1;
            digit_cnt  <= '0;
          end else if (press && last) begin
            st           <= ST_DONE;
            digit_cnt    <= CNT_W'(CODE_LEN);
            tries_left   <= 4'(MAX_TRIES);
            unlock_pulse <= 1'b1;
          end else if (press) begin
            digit_cnt <= digit_cnt + 1'b1;
          end
        end
        ST_ERROR: begin
          if (clear) st <= ST_IDLE;
        end
        ST_DONE: begin
          if (clear) begin
            st        <= ST_IDLE;
            digit_cnt <= '0;
          end
        end
        ST_LOCKED: st <= ST_LOCKED;
        default: begin
          st        <= ST_IDLE;
          digit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_verifier.sv
// Directed self-checking bench for code_verifier.
// Timeout vectors run only when VERIF_TIMEOUT_EN is defined.
module tb_code_verifier;

  localparam int SW_W = 10;
  localparam int CL   = 4;
  localparam int TCYC = 20;

  logic        clk;
  logic        rst;
  logic [9:0]  sw;
  logic [15:0] code;
  logic        clear;
  logic [2:0]  status;
  logic [2:0]  digit_cnt;
  logic [3:0]  tries_left;
  logic        unlock_pulse;

  int passed;
  int total;

  code_verifier #(
    .SW_W       (SW_W),
    .CODE_LEN   (CL),
    .MAX_TRIES  (3),
    .TIMEOUT_CYC(TCYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .code        (code),
    .clear       (clear),
    .status      (status),
    .digit_cnt   (digit_cnt),
    .tries_left  (tries_left),
    .unlock_pulse(unlock_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] sw;
    logic       clear;
    logic [2:0] st;
    logic [2:0] cnt;
    logic [3:0] tries;
    logic       pulse;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic [9:0] s, input logic c);
    sw    = s;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string name,
                            input logic [2:0] st,
                            input logic [2:0] cnt,
                            input logic [3:0] tr,
                            input logic       pu);
    check({name, ".status"}, 32'(status), 32'(st));
    check({name, ".digit_cnt"}, 32'(digit_cnt), 32'(cnt));
    check({name, ".tries_left"}, 32'(tries_left), 32'(tr));
    check({name, ".unlock_pulse"}, 32'(unlock_pulse), 32'(pu));
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b0;
    sw     = '0;
    clear  = 1'b0;
    code   = {4'd6, 4'd1, 4'd0, 4'd2};

    // status: 0 IDLE, 1 ENTRY, 2 DONE, 3 ERROR, 4 LOCKED
    vecs[0]  = '{10'h004, 1'b0, 3'd1, 3'd1, 4'd3, 1'b0};
    vecs[1]  = '{10'h000, 1'b0, 3'd1, 3'd1, 4'd3, 1'b0};
    vecs[2]  = '{10'h001, 1'b0, 3'd1, 3'd2, 4'd3, 1'b0};
    vecs[3]  = '{10'h000, 1'b0, 3'd1, 3'd2, 4'd3, 1'b0};
    vecs[4]  = '{10'h002, 1'b0, 3'd1, 3'd3, 4'd3, 1'b0};
    vecs[5]  = '{10'h000, 1'b0, 3'd1, 3'd3, 4'd3, 1'b0};
    vecs[6]  = '{10'h040, 1'b0, 3'd2, 3'd4, 4'd3, 1'b1};
    vecs[7]  = '{10'h000, 1'b0, 3'd2, 3'd4, 4'd3, 1'b0};
    vecs[8]  = '{10'h000, 1'b1, 3'd0, 3'd0, 4'd3, 1'b0};
    vecs[9]  = '{10'h008, 1'b0, 3'd3, 3'd0, 4'd2, 1'b0};
    vecs[10] = '{10'h000, 1'b1, 3'd0, 3'd0, 4'd2, 1'b0};
    vecs[11] = '{10'h008, 1'b0, 3'd3, 3'd0, 4'd1, 1'b0};
    vecs[12] = '{10'h000, 1'b1, 3'd0, 3'd0, 4'd1, 1'b0};
    vecs[13] = '{10'h200, 1'b0, 3'd4, 3'd0, 4'd0, 1'b0};
    vecs[14] = '{10'h000, 1'b1, 3'd4, 3'd0, 4'd0, 1'b0};
    vecs[15] = '{10'h004, 1'b0, 3'd4, 3'd0, 4'd0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    expect_all("reset", 3'd0, 3'd0, 4'd3, 1'b0);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].sw, vecs[i].clear);
      expect_all($sformatf("vec%0d", i), vecs[i].st,
                 vecs[i].cnt, vecs[i].tries, vecs[i].pulse);
    end

    // reset releases LOCKED
    sw  = '0;
    rst = 1'b0;
    step(10'h000, 1'b0);
    rst = 1'b1;
    expect_all("unlock_rst", 3'd0, 3'd0, 4'd3, 1'b0);

    // held and added switches give a single press
    for (int i = 0; i < 5; i++) step(10'h004, 1'b0);
    expect_all("hold", 3'd1, 3'd1, 4'd3, 1'b0);
    step(10'h005, 1'b0);
    expect_all("add_sw", 3'd1, 3'd1, 4'd3, 1'b0);
    step(10'h000, 1'b0);

    // multi-hot after digits 2,0
    step(10'h001, 1'b0);
    step(10'h000, 1'b0);
    expect_all("d0", 3'd1, 3'd2, 4'd3, 1'b0);
    step(10'h003, 1'b0);
    expect_all("multihot", 3'd3, 3'd0, 4'd2, 1'b0);
    step(10'h000, 1'b1);
    expect_all("err_clr", 3'd0, 3'd0, 4'd2, 1'b0);

    // code change mid-entry is ignored; DONE reloads tries
    step(10'h004, 1'b0);
    code = 16'h3579;
    step(10'h000, 1'b0);
    step(10'h001, 1'b0);
    step(10'h000, 1'b0);
    step(10'h002, 1'b0);
    step(10'h000, 1'b0);
    step(10'h040, 1'b0);
    expect_all("latched", 3'd2, 3'd4, 4'd3, 1'b1);

    // clear with a press in DONE: clear wins, held switch is spent
    step(10'h004, 1'b1);
    expect_all("clr_press", 3'd0, 3'd0, 4'd3, 1'b0);
    step(10'h004, 1'b0);
    expect_all("held_after", 3'd0, 3'd0, 4'd3, 1'b0);
    step(10'h000, 1'b0);
    code = {4'd6, 4'd1, 4'd0, 4'd2};

`ifdef VERIF_TIMEOUT_EN
    step(10'h004, 1'b0);
    for (int i = 0; i < TCYC - 1; i++) step(10'h000, 1'b0);
    expect_all("tmo_pre", 3'd1, 3'd1, 4'd3, 1'b0);
    step(10'h000, 1'b0);
    expect_all("tmo", 3'd3, 3'd0, 4'd2, 1'b0);
    step(10'h000, 1'b1);
    step(10'h004, 1'b0);
    for (int i = 0; i < TCYC - 1; i++) step(10'h000, 1'b0);
    step(10'h001, 1'b0);
    expect_all("tmo_press", 3'd1, 3'd2, 4'd2, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/code_verifier.md
Name: code_verifier

Overview:
- Parametrised switch-entry combination-lock checker.
- Compares a sequence of single-switch presses on the sw bus against a CODE_LEN-digit code held on an input port.
- Counts failed attempts and enters a lockout state after MAX_TRIES failures.
- Sits between the debounced board switches and the unlock/status indicators; it is the generalised successor of the fixed 4-digit verifier.

Parameters:
- SW_W, 10, number of switch inputs.
- CODE_LEN, 4, digits per code, 1..16.
- MAX_TRIES, 3, failed attempts allowed before LOCKED, 1..15.
- TIMEOUT_CYC, 1000000, maximum cycles between presses once entry has started; used only with VERIF_TIMEOUT_EN.
- Shared widths: IDX_W = $clog2(SW_W), CNT_W = $clog2(CODE_LEN+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low).
- sw  in  SW_W  switch levels, already debounced.
- code  in  CODE_LEN*IDX_W  expected switch indices; digit k is code[k*IDX_W +: IDX_W]; digit 0 is entered first.
- clear  in  1  leave ERROR or DONE and return to IDLE.
- status  out  3  0=IDLE, 1=ENTRY, 2=DONE, 3=ERROR, 4=LOCKED.
- digit_cnt  out  CNT_W  digits accepted in the current attempt.
- tries_left  out  4  remaining attempts.
- unlock_pulse  out  1  one-cycle pulse on entering DONE.

Behaviour:
- Reset, sampled on the rising clk edge with rst==0:
  - status=IDLE, digit_cnt=0, tries_left=MAX_TRIES, unlock_pulse=0.
  - sw_last=0, code register cleared, timer=0.
  - Reset mid-operation aborts everything, including LOCKED.
- Press event:
  - sw_last is a registered copy of sw.
  - press = (sw!=0) && (sw_last==0). Holding or adding switches without first returning to all-zero produces no new press.
- Digit valid when sw is one-hot and its bit index equals the expected digit. Zero-hot is not a press. Multi-hot is always a mismatch.
- State transitions (all updates occur at the edge where press is high, so status changes 1 cycle after sw first goes nonzero):
  - IDLE, press:
    - Latch code into an internal register; code changes afterwards are ignored until the next IDLE.
    - Check the press against digit 0.
    - Match with CODE_LEN==1 -> DONE. Match otherwise -> ENTRY with digit_cnt=1.
    - Mismatch -> fail.
  - ENTRY, press:
    - Match on the final digit -> DONE with digit_cnt=CODE_LEN.
    - Match otherwise -> digit_cnt+1.
    - Mismatch -> fail.
  - fail:
    - tries_left decrements.
    - If the new value is 0 -> LOCKED; otherwise -> ERROR.
    - digit_cnt=0.
  - ERROR: presses ignored. clear -> IDLE.
  - DONE:
    - unlock_pulse high only on the first DONE cycle.
    - tries_left reloads to MAX_TRIES.
    - clear -> IDLE with digit_cnt=0.
  - LOCKED: sticky; only rst exits. clear and presses are ignored.
- clear in IDLE or ENTRY has no effect.
- A press and clear in the same cycle in ERROR/DONE: clear wins and the press is discarded. sw_last still updates, so the held switch does not count later.

Optional Feature:
- Macro VERIF_TIMEOUT_EN.
- Defined:
  - In ENTRY a counter increments every cycle and resets to 0 on each press.
  - When it reaches TIMEOUT_CYC-1 with no press, this is treated as a fail: tries_left decrements, then ERROR or LOCKED.
  - A press on the same cycle as the timeout wins.
- Undefined: no timer logic; ENTRY waits indefinitely.

Decomposition:
- Package code_verifier_pkg: status enum (IDLE..LOCKED, 3 bits) and function onehot_index(sw) returning {valid, index}.
- Sub-module press_detect: holds sw_last and emits press, onehot_valid and index. It is reusable by other switch-input blocks.

Test Plan (defaults; code = {6,1,0,2}, i.e. digits 2,0,1,6):
- Reset, then presses sw=0x004, 0x001, 0x002, 0x040, each separated by sw=0 -> digit_cnt 1,2,3; status=DONE; unlock_pulse high for exactly 1 cycle; tries_left=3.
- From IDLE, sw=0x008 -> status=ERROR, tries_left=2. clear -> IDLE. Three total failures -> LOCKED; clear has no effect; rst=0 for 1 cycle -> IDLE, tries_left=3.
- Hold sw=0x004 for 5 cycles, then sw=0x005 without releasing -> single accepted digit; no second press; status stays ENTRY, digit_cnt=1.
- After digits 2,0, press sw=0x003 (multi-hot) -> ERROR, tries_left=2.
- Change code to a different value while in ENTRY after digit 2 -> the original code is still required; completing 0,1,6 reaches DONE.
- VERIF_TIMEOUT_EN with TIMEOUT_CYC=20: press digit 2, then idle 20 cycles -> ERROR, tries_left=2. The same sequence with a press at cycle 19 -> stays ENTRY.
